// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//
// Round-robin burst arbiter that shares one NUM_REQ:1 data mux between
// NUM_REQ valid/ready producers and a single downstream sink.
//
// A grant lasts at most MAX_BURST beats. Forwarded beats go into a one-entry
// registered output stage, which accepts a new beat whenever it is empty or
// being drained in the same cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no owner; ready goes to the round-robin winner in the same cycle
// ST_BURST | owner held; only the owner may transfer, up to MAX_BURST beats
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   req_valid_i  per-requester valid
//   req_data_i   per-requester data beat (unpacked array)
//   req_ready_o  per-requester ready, at most one bit high
//   out_valid_o  registered output valid
//   out_data_o   registered output data
//   out_sel_o    index of the requester that produced out_data_o
//   out_ready_i  downstream ready
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [DATA_WIDTH-1:0]      req_data_i [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       out_valid_o,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic [$clog2(NUM_REQ)-1:0] out_sel_o,
    input  logic                       out_ready_i
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_LEN = CNT_W'(MAX_BURST);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       owner_q, owner_d;
    logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]       cnt_inc;

    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [SEL_W-1:0]       out_sel_q;

    logic                   load_en;
    logic                   win_found;
    logic [SEL_W-1:0]       win_idx;
    logic [SEL_W-1:0]       scan_idx;
    logic [NUM_REQ-1:0]     ready;
    logic [SEL_W-1:0]       xfer_idx;
    logic                   xfer;

    // Cyclic increment; NUM_REQ need not be a power of two.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign load_en = !out_valid_q || out_ready_i;
    assign cnt_inc = beat_cnt_q + 1'b1;

    // First valid requester scanning cyclically from rr_ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = next_idx(scan_idx);
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (MAX_BURST == 1) begin
                        // Single-beat grants never leave IDLE.
                        rr_ptr_d = next_idx(win_idx);
                    end else begin
                        state_d    = ST_BURST;
                        owner_d    = win_idx;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
            end
            ST_BURST: begin
                if (load_en) begin
                    if (req_valid_i[owner_q]) begin
                        if (cnt_inc == BURST_LEN) begin
                            state_d    = ST_IDLE;
                            rr_ptr_d   = next_idx(owner_q);
                            beat_cnt_d = '0;
                        end else begin
                            beat_cnt_d = cnt_inc;
                        end
                    end else begin
                        // Owner went quiet: release the grant, costs one gap cycle.
                        state_d    = ST_IDLE;
                        rr_ptr_d   = next_idx(owner_q);
                        beat_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        ready    = '0;
        xfer_idx = win_idx;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    ready[win_idx] = load_en;
                end
            end
            ST_BURST: begin
                ready[owner_q] = load_en;
                xfer_idx       = owner_q;
            end
            default: ready = '0;
        endcase
    end

    assign xfer = req_valid_i[xfer_idx] && ready[xfer_idx];

    // Ready is gated so it drops immediately on an asynchronous reset.
    assign req_ready_o = reset ? '0 : ready;

    // ---------------- output stage ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= req_data_i[xfer_idx];
            out_sel_q   <= xfer_idx;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Directed bench for rr_mux_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Each requester is a simple producer: it holds valid while it has beats
// left and advances its data by one after every accepted beat. Requester k
// starts at data k*16 unless a step sets otherwise.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [DW-1:0] req_data [N];
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          out_ready;

    int            n_cmp = 0;
    int            n_err = 0;
    int            rem [N];
    logic [DW-1:0] nxt [N];

    rr_mux_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] exp);
        chk(tag, 32'(req_ready), 32'(exp));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic chk_out(input string tag, input logic [1:0] sel, input logic [7:0] data);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sel"},   32'(out_sel),   32'(sel));
        chk({tag, "_data"},  32'(out_data),  32'(data));
    endtask

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            req_valid[k] = (rem[k] != 0);
            req_data[k]  = nxt[k];
        end
    endtask

    task automatic init_prod();
        for (int k = 0; k < N; k++) begin
            rem[k] = 0;
            nxt[k] = 8'(k * 16);
        end
    endtask

    // One clock: note accepted beats, step past the edge, update producers.
    task automatic cycle();
        logic [N-1:0] fire;
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (fire[k]) begin
                rem[k]--;
                nxt[k]++;
            end
        end
        apply();
        #1;
    endtask

    initial begin
        logic [1:0] es;
        logic [7:0] ed;

        reset     = 1'b0;
        out_ready = 1'b1;
        init_prod();
        apply();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset state, with every requester asking
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_sel",   32'(out_sel),   32'd0);
        for (int k = 0; k < N; k++) rem[k] = 100;
        apply();
        #1;
        chk_rdy("rst_ready", 4'b0000);

        // all four continuously valid: 0x4, 1x4, 2x4, 3x4, 0
        reset = 1'b0;
        #1;
        chk_rdy("rr_first_grant", 4'b0001);
        for (int n = 0; n < 17; n++) begin
            cycle();
            es = 2'((n / 4) % 4);
            ed = 8'(int'(es) * 16 + ((n < 16) ? (n % 4) : 4));
            chk_out($sformatf("rr_beat%0d", n), es, ed);
        end

        // asynchronous reset mid-burst with out_valid high
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data",  32'(out_data),  32'd0);
        chk("arst_sel",   32'(out_sel),   32'd0);
        chk_rdy("arst_ready", 4'b0000);
        init_prod();
        rem[0] = 1;
        rem[2] = 1;
        apply();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_rdy("post_rst_grant", 4'b0001);
        cycle();
        chk_out("post_rst_r0", 2'd0, 8'h00);
        cycle();
        chk_idle("post_rst_gap0");
        chk_rdy("post_rst_g2", 4'b0100);
        cycle();
        chk_out("post_rst_r2", 2'd2, 8'h20);
        cycle();
        chk_idle("post_rst_gap2");

        // wrap: rr_ptr=3, requests 0 and 3
        init_prod();
        rem[0] = 1;
        rem[3] = 1;
        apply();
        #1;
        chk_rdy("wrap_g3", 4'b1000);
        cycle();
        chk_out("wrap_r3", 2'd3, 8'h30);
        chk_rdy("wrap_owner3", 4'b1000);
        cycle();
        chk_idle("wrap_gap3");
        chk_rdy("wrap_g0", 4'b0001);
        cycle();
        chk_out("wrap_r0", 2'd0, 8'h00);
        cycle();
        chk_idle("wrap_gap0");

        // req 1 for two beats then drops, req 3 waiting (rr_ptr=1)
        init_prod();
        rem[1] = 2;
        rem[3] = 3;
        apply();
        #1;
        chk_rdy("drop_g1", 4'b0010);
        cycle();
        chk_out("drop_r1a", 2'd1, 8'h10);
        cycle();
        chk_out("drop_r1b", 2'd1, 8'h11);
        chk_rdy("drop_owner1", 4'b0010);
        cycle();
        chk_idle("drop_gap1");
        chk_rdy("drop_g3", 4'b1000);
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk_out($sformatf("drop_r3_%0d", n), 2'd3, 8'(8'h30 + n));
        end
        cycle();
        chk_idle("drop_gap3");
        // rr_ptr must now be 0: req 0 beats req 1
        init_prod();
        rem[0] = 1;
        rem[1] = 1;
        apply();
        #1;
        chk_rdy("ptr0_g0", 4'b0001);
        cycle();
        chk_out("ptr0_r0", 2'd0, 8'h00);
        cycle();
        chk_idle("ptr0_gap0");
        chk_rdy("ptr0_g1", 4'b0010);
        cycle();
        chk_out("ptr0_r1", 2'd1, 8'h10);
        cycle();
        chk_idle("ptr0_gap1");

        // only req 2, data A0..A9, back-to-back bursts (rr_ptr=2)
        init_prod();
        nxt[2] = 8'hA0;
        rem[2] = 10;
        apply();
        #1;
        chk_rdy("solo_g2", 4'b0100);
        for (int n = 0; n < 10; n++) begin
            cycle();
            chk_out($sformatf("solo_b%0d", n), 2'd2, 8'(8'hA0 + n));
        end
        cycle();
        chk_idle("solo_gap");

        // downstream stall mid-burst (rr_ptr=3), req 2 waiting for its turn
        init_prod();
        rem[1] = 6;
        rem[2] = 1;
        apply();
        #1;
        chk_rdy("stall_g1", 4'b0010);
        cycle();
        chk_out("stall_b0", 2'd1, 8'h10);
        cycle();
        chk_out("stall_b1", 2'd1, 8'h11);
        out_ready = 1'b0;
        #1;
        chk_rdy("stall_rdy_low", 4'b0000);
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk_out($sformatf("stall_hold%0d", n), 2'd1, 8'h11);
            chk_rdy($sformatf("stall_hold%0d_rdy", n), 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk_rdy("stall_resume", 4'b0010);
        cycle();
        chk_out("stall_b2", 2'd1, 8'h12);
        cycle();
        chk_out("stall_b3", 2'd1, 8'h13);
        chk_rdy("stall_burst_end_g2", 4'b0100);
        cycle();
        chk_out("stall_r2", 2'd2, 8'h20);
        cycle();
        chk_idle("stall_gap2");
        chk_rdy("stall_g1_again", 4'b0010);
        cycle();
        chk_out("stall_b4", 2'd1, 8'h14);
        cycle();
        chk_out("stall_b5", 2'd1, 8'h15);
        cycle();
        chk_idle("stall_gap1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
